noc_output_arbiter: RTL
=======================

Name: noc_output_arbiter

Overview:
- Round-robin arbiter for one router output channel, shared by NUM_PORTS upstream single-entry flit buffers (N, S, E, W, local).
- Each cycle, when the downstream single-entry buffer is not full, it selects one non-empty, unmasked upstream buffer.
- In that same cycle it pops the selected buffer and pushes its flit downstream.
- Keeps a per-port saturating count of forwarded flits for performance monitoring.

Parameters:
- PAC_WIDTH, 64, flit width in bits.
- NUM_PORTS, 5, number of requesting upstream buffers (2..8).
- CNT_WIDTH, 16, width of each per-port forwarded-flit counter.
- IDX_WIDTH, $clog2(NUM_PORTS), derived; width of grant index and pointer (not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- up_empty  in  NUM_PORTS  empty flag of each upstream buffer; bit i=1 means port i has no flit.
- up_data  in  NUM_PORTS*PAC_WIDTH  upstream flit outputs; port i occupies bits [i*PAC_WIDTH +: PAC_WIDTH].
- up_ren  out  NUM_PORTS  read enable to each upstream buffer; one-hot or zero.
- port_mask  in  NUM_PORTS  bit i=1 excludes port i from arbitration.
- dn_full  in  1  full flag of the downstream buffer.
- dn_wen  out  1  write enable to the downstream buffer.
- dn_data  out  PAC_WIDTH  flit to the downstream buffer.
- grant_valid  out  1  a transfer occurs this cycle (equals dn_wen).
- grant_idx  out  IDX_WIDTH  index of the granted port; 0 when grant_valid=0.
- cnt_clr  in  1  synchronous clear of all forwarded-flit counters.
- fwd_cnt  out  NUM_PORTS*CNT_WIDTH  per-port forwarded-flit counters; port i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- Eligibility: req[i] = ~up_empty[i] & ~port_mask[i].
- Grant is combinational and zero-latency. When dn_full=0, reset=0 and any req is set, the grant g is the first set req[i] scanning i = rr_ptr, rr_ptr+1, …, wrapping modulo NUM_PORTS.
- Wrap for non-power-of-two NUM_PORTS: index NUM_PORTS-1 wraps to 0. The pointer never holds a value >= NUM_PORTS.
- On grant, all of the following hold in the same cycle:
  - up_ren = one-hot(g);
  - dn_wen = 1;
  - dn_data = up_data slice g;
  - grant_valid = 1;
  - grant_idx = g.
- The upstream buffer releases its entry and the downstream buffer captures the flit at the same edge; no flit is lost or duplicated.
- No grant (dn_full=1, no req, or reset=1):
  - up_ren = 0, dn_wen = 0, grant_valid = 0, grant_idx = 0;
  - dn_data = 0, so idle data is deterministic.
- up_ren must never be asserted to a port with up_empty=1 or port_mask=1, nor while dn_full=1.
- Round-robin pointer rr_ptr (IDX_WIDTH bits, registered):
  - reset value 0;
  - after a grant to g, rr_ptr <= (g == NUM_PORTS-1) ? 0 : g+1;
  - no grant means rr_ptr holds.
- Fairness: with every port continuously eligible, each port is granted exactly once in any NUM_PORTS consecutive grants.
- Throughput: the downstream buffer is single-entry, so back-to-back grants occur only if the downstream side drains in the same cycle it is written. The arbiter reacts purely to dn_full and never speculates.
- Counters:
  - fwd_cnt[g] increments by 1 on each grant to g and saturates at 2^CNT_WIDTH-1 with no wrap.
  - cnt_clr=1 zeroes all counters. A grant in the same cycle is still performed, but the cleared counters read 0 next cycle (clear wins).
- Reset:
  - rr_ptr=0, all fwd_cnt=0.
  - All outputs are forced to their no-grant values while reset=1, including mid-transfer: reset has priority over an active grant in that cycle.
- port_mask changes take effect combinationally in the same cycle; rr_ptr is not modified by mask changes.

Test Plan:
- Reset, then all up_empty=1, dn_full=0 -> up_ren=0, dn_wen=0, grant_idx=0, all fwd_cnt=0 for 10 cycles.
- Ports 1 and 3 non-empty, rr_ptr=0, dn_full=0 -> cycle 1 grants 1 (up_ren=5'b00010, dn_data=port1 flit). Next eligible cycle grants 3 (up_ren=5'b01000). rr_ptr then = 4.
- All 5 ports continuously non-empty, dn_full=0 every cycle -> grant order 0,1,2,3,4,0,1 (wraps 4→0). After 10 grants each fwd_cnt=2.
- dn_full=1 with ports 0–4 non-empty for 3 cycles -> no up_ren, no dn_wen, rr_ptr unchanged. dn_full drops -> grant to the port at rr_ptr in that cycle.
- port_mask=5'b00101, all ports non-empty -> only ports 1, 3, 4 are granted, in order 1,3,4,1. Assert reset during a grant cycle -> up_ren=0, dn_wen=0 that cycle; next cycle rr_ptr=0 and counters are 0.
- CNT_WIDTH=4, port 2 granted 17 times -> fwd_cnt[2]=15 (saturated). cnt_clr asserted together with a grant -> grant performed, fwd_cnt[2]=0 next cycle.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Round-robin arbiter for one router output channel. It picks one non-empty,
// unmasked upstream flit buffer per cycle and keeps saturating per-port flit counters.

module noc_fwd_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // A clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && (cnt != {CNT_WIDTH{1'b1}}))
      cnt <= cnt + CNT_WIDTH'(1);
  end
endmodule

module noc_output_arbiter #(
  parameter int PAC_WIDTH = 64,
  parameter int NUM_PORTS = 5,
  parameter int CNT_WIDTH = 16,
  parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           up_empty,
  input  logic [NUM_PORTS*PAC_WIDTH-1:0] up_data,
  output logic [NUM_PORTS-1:0]           up_ren,
  input  logic [NUM_PORTS-1:0]           port_mask,
  input  logic                           dn_full,
  output logic                           dn_wen,
  output logic [PAC_WIDTH-1:0]           dn_data,
  output logic                           grant_valid,
  output logic [IDX_WIDTH-1:0]           grant_idx,
  input  logic                           cnt_clr,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] fwd_cnt
);
  logic [NUM_PORTS-1:0][PAC_WIDTH-1:0] up_flit;
  logic [NUM_PORTS-1:0]                req;
  logic [IDX_WIDTH-1:0]                rr_ptr;
  logic [IDX_WIDTH-1:0]                sel;
  logic                                found;
  logic                                grant;
  int unsigned                         p;

  assign up_flit = up_data;
  assign req     = ~up_empty & ~port_mask;

  // Scan from rr_ptr with an explicit wrap so non-power-of-two port counts stay in range.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    p     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = int'(rr_ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && req[IDX_WIDTH'(p)]) begin
        found = 1'b1;
        sel   = IDX_WIDTH'(p);
      end
    end
  end

  assign grant       = found && !dn_full && !reset;
  assign grant_valid = grant;
  assign dn_wen      = grant;
  assign grant_idx   = grant ? sel : '0;
  assign up_ren      = grant ? (NUM_PORTS'(1) << sel) : '0;
  assign dn_data     = grant ? up_flit[sel] : '0;

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (grant)
      rr_ptr <= (sel == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : sel + IDX_WIDTH'(1);
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    noc_fwd_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (grant && (sel == IDX_WIDTH'(i))),
      .cnt   (fwd_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule
